// File: rtl/regfile_sb_if.sv
// regfile_sb_if
// Bus bundle for the scoreboarded register file. The master side (ID/EX/WB
// pipeline) drives the read addresses, the issue request and the writeback
// lanes. The slave side (regfile_sb) returns read data, busy flags, issue
// readiness and the sticky protocol error.
//
// Signals:
//   rd_addr   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data   NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy   NUM_RD       addressed register has outstanding writes
//   iss_en    1            issue request for destination iss_rd
//   iss_rd    AW           issued destination register
//   iss_ready 1            issue would be accepted this cycle
//   wr_en     NUM_WR       writeback valid per lane
//   wr_addr   NUM_WR*AW    writeback addresses
//   wr_data   NUM_WR*XLEN  writeback data
//   err       1            sticky protocol error (counter underflow)
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   iss_en;
  logic [AW-1:0]          iss_rd;
  logic                   iss_ready;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   err;

  modport master (
    output rd_addr, iss_en, iss_rd, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, iss_ready, err
  );

  modport slave (
    input  rd_addr, iss_en, iss_rd, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, iss_ready, err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
// Multi-port integer register file with a per-register pending-write
// scoreboard. Register 0 is hardwired to zero. Each register carries a PW-bit
// counter of outstanding writes: an accepted issue adds one, every valid
// writeback lane targeting the register subtracts one. A decrement below zero
// clamps the counter at 0 and sets the sticky err flag.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset, clears data, counters and err
//   bus  regfile_sb_if slave modport (reads, issue, writeback lanes, err)
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, same-cycle writeback data is forwarded
//                      to the read ports and rd_busy reflects the counter
//                      after this cycle's writebacks. Sequential behaviour is
//                      identical in both builds.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2,
  parameter int PW     = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int DW = $clog2(NUM_WR + 1);
  // Wide enough to hold cnt+1 and the lane count without wrapping.
  localparam int SW = ((PW > DW) ? PW : DW) + 1;

  logic [XLEN-1:0]  mem      [NREGS];
  logic [PW-1:0]    cnt      [NREGS];
  logic [PW-1:0]    cnt_next [NREGS];
  logic [DW-1:0]    dec      [NREGS];
  logic [NREGS-1:0] under;
  logic             err_q;
  logic             iss_acc;
  logic [SW-1:0]    sum;
  logic [AW-1:0]    ra;

  assign bus.err = err_q;

  // A saturated counter refuses further issues; register 0 always accepts.
  always_comb begin
    bus.iss_ready = 1'b1;
    if (bus.iss_rd != '0 && cnt[bus.iss_rd] == {PW{1'b1}})
      bus.iss_ready = 1'b0;
  end

  assign iss_acc = bus.iss_en && bus.iss_ready;

  // Count how many writeback lanes hit each register this cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r))
          dec[r] = dec[r] + DW'(1);
      end
    end
  end

  // Next counter value: add the issue first, then subtract the lanes so a
  // same-cycle issue and writeback net out instead of flagging underflow.
  always_comb begin
    sum   = '0;
    under = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_next[r] = '0;
      if (r != 0) begin
        sum = SW'(cnt[r]) + SW'(iss_acc && bus.iss_rd == AW'(r));
        if (SW'(dec[r]) > sum)
          under[r] = 1'b1;
        else
          cnt_next[r] = PW'(sum - SW'(dec[r]));
      end
    end
  end

  // State update. Lanes are written in ascending order so the
  // highest-index lane wins when several target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      if (|under)
        err_q <= 1'b1;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= cnt_next[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0)
          mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (ra != '0) begin
`ifdef REGFILE_BYPASS_EN
        bus.rd_data[i*XLEN +: XLEN] = mem[ra];
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == ra)
            bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
        end
        // Busy after this cycle's writebacks, clamped at zero.
        bus.rd_busy[i] = SW'(cnt[ra]) > SW'(dec[ra]);
`else
        bus.rd_data[i*XLEN +: XLEN] = mem[ra];
        bus.rd_busy[i]              = cnt[ra] != '0;
`endif
      end
    end
  end
endmodule
